// File: rtl/i2c_write_sequencer.sv
// -----------------------------------------------------------------------------
// i2c_write_sequencer
//
// Command-queue stage in front of i2c_master. Buffers single-byte write
// commands {7-bit device address, 8-bit data} in a small FIFO and hands them
// to the master one at a time over a start/busy/done handshake. A NACK or an
// accept timeout re-issues the same head entry up to MAX_RETRY times. After
// that the entry is dropped and the sticky error flag and the error counter
// are updated. A fixed idle gap of GAP_CYCLES clocks follows every attempt.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   cmd_valid/ready    command push handshake (push when both high)
//   cmd_addr/data      command payload
//   fifo_level         entries currently queued (updates the cycle after)
//   busy               FIFO non-empty or sequencer not idle
//   err, err_clr       sticky drop flag and its synchronous clear
//   err_cnt            dropped-entry count, saturates at 255
//   m_start            one-cycle request to the master
//   m_device_addr/data payload to the master, held from m_start until done
//   m_busy/done/nack   master status; m_nack is qualified by m_done
// -----------------------------------------------------------------------------
module i2c_write_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned GAP_CYCLES     = 16,
    parameter int unsigned ACCEPT_TIMEOUT = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [6:0]                  cmd_addr,
    input  logic [7:0]                  cmd_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        err,
    input  logic                        err_clr,
    output logic [7:0]                  err_cnt,
    output logic                        m_start,
    output logic [6:0]                  m_device_addr,
    output logic [7:0]                  m_data,
    input  logic                        m_busy,
    input  logic                        m_done,
    input  logic                        m_nack
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned RtyW = $clog2(MAX_RETRY + 2);
    localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
    localparam int unsigned TmoW = $clog2(ACCEPT_TIMEOUT + 1);

    localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);
    localparam logic [RtyW-1:0] RtyMax  = RtyW'(MAX_RETRY);
    localparam logic [GapW-1:0] GapLast = GapW'(GAP_CYCLES - 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(ACCEPT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitAccept,
        StWaitDone,
        StFail,
        StGap
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e          state_q, state_d;

    logic [14:0]     mem_q [FIFO_DEPTH];
    logic [14:0]     mem_d [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] level_q, level_d;
    logic            cmd_ready_q, cmd_ready_d;

    logic [RtyW-1:0] retry_q, retry_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic [TmoW-1:0] tmo_q, tmo_d;

    logic            m_start_q, m_start_d;
    logic [6:0]      m_addr_q, m_addr_d;
    logic [7:0]      m_data_q, m_data_d;
    logic            err_q, err_d;
    logic [7:0]      err_cnt_q, err_cnt_d;

    logic            push;
    logic            pop;
    logic            drop;
    logic [14:0]     head;

    assign push = cmd_valid && cmd_ready_q;
    assign head = mem_q[rd_ptr_q];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        gap_d     = gap_q;
        tmo_d     = tmo_q;
        m_start_d = 1'b0;
        m_addr_d  = m_addr_q;
        m_data_d  = m_data_q;
        pop       = 1'b0;
        drop      = 1'b0;

        case (state_q)
            StIdle: begin
                // Outputs are registered, so the head is latched on the way
                // into StIssue and is visible for the whole m_start cycle.
                if ((level_q != '0) && !m_busy) begin
                    state_d   = StIssue;
                    m_start_d = 1'b1;
                    m_addr_d  = head[14:8];
                    m_data_d  = head[7:0];
                end
            end

            StIssue: begin
                tmo_d   = '0;
                state_d = StWaitAccept;
            end

            StWaitAccept, StWaitDone: begin
                // A done seen before busy is handled exactly like a normal
                // completion; the master may finish faster than we sample.
                if (m_done) begin
                    if (m_nack) begin
                        state_d = StFail;
                    end else begin
                        pop     = 1'b1;
                        retry_d = '0;
                        gap_d   = '0;
                        state_d = StGap;
                    end
                end else if (state_q == StWaitAccept) begin
                    if (m_busy) begin
                        state_d = StWaitDone;
                    end else if (tmo_q == TmoLast) begin
                        state_d = StFail;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end

            StFail: begin
                if (retry_q < RtyMax) begin
                    retry_d = retry_q + 1'b1;
                end else begin
                    pop     = 1'b1;
                    drop    = 1'b1;
                    retry_d = '0;
                end
                gap_d   = '0;
                state_d = StGap;
            end

            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // FIFO pointers and occupancy. Ready is derived from the next level so it
    // is already low in the cycle after the push that fills the queue.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push) begin
            mem_d[wr_ptr_q] = {cmd_addr, cmd_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        level_d     = level_q + LvlW'(push) - LvlW'(pop);
        cmd_ready_d = (level_d != LvlFull);
    end

    // Set wins over clear so a drop is never lost to a coincident err_clr.
    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (drop) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            cmd_ready_q <= 1'b1;
            retry_q     <= '0;
            gap_q       <= '0;
            tmo_q       <= '0;
            m_start_q   <= 1'b0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            cmd_ready_q <= cmd_ready_d;
            retry_q     <= retry_d;
            gap_q       <= gap_d;
            tmo_q       <= tmo_d;
            m_start_q   <= m_start_d;
            m_addr_q    <= m_addr_d;
            m_data_q    <= m_data_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign cmd_ready     = cmd_ready_q;
    assign fifo_level    = level_q;
    assign busy          = (state_q != StIdle) || (level_q != '0);
    assign err           = err_q;
    assign err_cnt       = err_cnt_q;
    assign m_start       = m_start_q;
    assign m_device_addr = m_addr_q;
    assign m_data        = m_data_q;

    // -------------------------------------------------------------------------
    // Internal invariants
    // -------------------------------------------------------------------------
    a_start_in_issue : assert property (@(posedge clk) disable iff (!rst_n)
        m_start_q |-> (state_q == StIssue));

    a_level_bounded : assert property (@(posedge clk) disable iff (!rst_n)
        level_q <= LvlFull);

    a_ready_matches_level : assert property (@(posedge clk) disable iff (!rst_n)
        cmd_ready_q == (level_q != LvlFull));

endmodule

// File: doc/i2c_write_sequencer.md
Name: i2c_write_sequencer

Overview:
Command-queue stage directly upstream of i2c_master. It buffers single-byte write commands of the form {7-bit device address, 8-bit data} in a small FIFO. It issues them one at a time to the master through a start/busy/done handshake. On address or data NACK it retries a bounded number of times, then drops the entry and records an error. It inserts a programmable bus-idle gap between transactions.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2
MAX_RETRY, 3, re-issues allowed after a NACK before the entry is dropped
GAP_CYCLES, 16, clk cycles of idle between consecutive transactions; >= 1
ACCEPT_TIMEOUT, 32, clk cycles to wait for m_busy after m_start before the attempt counts as failed

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
cmd_valid  in  1  command present on cmd_addr/cmd_data
cmd_ready  out  1  FIFO can accept; push when cmd_valid && cmd_ready
cmd_addr  in  7  target device address
cmd_data  in  8  byte to write
fifo_level  out  $clog2(FIFO_DEPTH)+1  entries currently queued
busy  out  1  FIFO non-empty or FSM not IDLE
err  out  1  sticky: an entry was dropped after retries exhausted or timeout
err_clr  in  1  synchronous clear of err (err_cnt unaffected)
err_cnt  out  8  count of dropped entries, saturates at 255
m_start  out  1  one-cycle request to i2c_master
m_device_addr  out  7  address to master, stable from m_start until m_done
m_data  out  8  data to master, stable from m_start until m_done
m_busy  in  1  master transaction in progress
m_done  in  1  one-cycle pulse, transaction finished
m_nack  in  1  valid with m_done; 1 = address or data NACK

Behaviour:
- Reset: FIFO emptied, state IDLE, retry/gap/timeout counters 0.
- Reset values: m_start=0, m_device_addr=0, m_data=0, err=0, err_cnt=0, fifo_level=0, busy=0, cmd_ready=1.
- Reset mid-transaction aborts silently; no retry or error is recorded.
- FIFO: cmd_ready = !full, registered. A push in the same cycle as a pop while full is refused (cmd_ready=0 that cycle).
- FIFO: the head entry is not popped until its transaction completes, success or drop. Pointers wrap modulo FIFO_DEPTH.
- fifo_level updates the cycle after the push/pop.
- FSM states:
  IDLE -> ISSUE when FIFO non-empty && !m_busy.
  ISSUE (1 cycle): latch head into m_device_addr/m_data, assert m_start=1; -> WAIT_ACCEPT.
  WAIT_ACCEPT: m_busy=1 -> WAIT_DONE.
  WAIT_ACCEPT: m_done before m_busy is treated as if from WAIT_DONE.
  WAIT_ACCEPT: ACCEPT_TIMEOUT cycles without m_busy -> FAIL.
  WAIT_DONE: m_done && !m_nack -> pop head, clear retry count, -> GAP.
  WAIT_DONE: m_done && m_nack -> FAIL.
  FAIL (1 cycle): if retry_cnt < MAX_RETRY, retry_cnt++, no pop, -> GAP.
  FAIL: else pop head, clear retry_cnt, err<=1, err_cnt++ (saturating), -> GAP.
  GAP: count GAP_CYCLES cycles, then -> IDLE.
- Timing: minimum latency from a push into an empty idle block to m_start is 2 cycles (FIFO write, IDLE->ISSUE).
- Retry re-issues the same head entry with identical address and data.
- err_clr: an err_clr coinciding with a new drop leaves err=1 (set wins).
- busy = (state != IDLE) || (fifo_level != 0).
- m_start is never asserted while m_busy=1 or outside ISSUE.
- Total attempts per entry = 1 + MAX_RETRY.

Test Plan:
- Push {0x3C,0xA5}; master busy 20 cycles then done, nack=0 -> m_start one cycle, addr 0x3C, data 0xA5; entry popped; next m_start no earlier than 16 cycles after m_done; err=0.
- Push 4 entries back-to-back with master held busy -> cmd_ready falls after 4th push, fifo_level=4; 5th push refused. Entries issue in FIFO order; level drains 4->0; busy falls after last GAP.
- Master NACKs every attempt on {0x50,0x11} -> exactly 4 m_start pulses, all with 0x50/0x11; then entry dropped, err=1, err_cnt=1; next entry issued normally.
- NACK twice, then ACK -> 3 m_start pulses, err stays 0, retry count cleared; following entry gets a full 4 attempts.
- m_busy never asserts after m_start -> failure after 32 cycles, retried per MAX_RETRY; err_cnt increments once per dropped entry. err_clr pulse -> err=0, err_cnt unchanged.
- Assert rst_n=0 during WAIT_DONE with 3 entries queued -> all outputs return to reset values immediately; after release fifo_level=0, no m_start.
